// File: rtl/divider_if.sv
// divider_if: operand/result bundle between a divider and its requester.
//   start, signed_op, dividend, divisor : requester -> divider
//   quotient, remainder, done, busy, div_by_zero : divider -> requester (registered)
interface divider_if #(parameter int WIDTH = 64);
    logic             start, signed_op, done, busy, div_by_zero;
    logic [WIDTH-1:0] dividend, divisor, quotient, remainder;
    modport master(output start, signed_op, dividend, divisor,
                   input quotient, remainder, done, busy, div_by_zero);
    modport slave(input start, signed_op, dividend, divisor,
                  output quotient, remainder, done, busy, div_by_zero);
endinterface

// File: rtl/divider.sv
// divider: radix-2 restoring divider, one quotient bit per clock, MSB first.
//   clock : rising-edge clock
//   reset : asynchronous active-low reset
//   bus   : divider_if.slave (start/operands in, registered results and flags out)
// Optional signed division is enabled by defining DIVIDER_SIGNED_EN; otherwise
// signed_op is ignored and only unsigned division is built.
module divider #(parameter int WIDTH = 64) (
    input logic      clock,
    input logic      reset,
    divider_if.slave bus
);
    localparam int CW = WIDTH > 1 ? $clog2(WIDTH) : 1;
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
    logic [WIDTH-1:0] quotient_q, quotient_d, remainder_q, remainder_d;
    logic             done_q, done_d, busy_q, busy_d, dbz_q, dbz_d;
    logic             dz_q, dz_d, short_q, short_d;
    logic             acc, ovf;
    logic [WIDTH:0]   sh, diff;
    logic [WIDTH-1:0] qn, rn, a_mag, b_mag, q_res, r_res;
    // quo_q shifts dividend bits out at the top while quotient bits enter at the bottom
    assign acc  = bus.start && state_q != BUSY;
    assign sh   = {rem_q, quo_q[WIDTH-1]};
    assign diff = sh - {1'b0, dvs_q};
    assign qn   = {quo_q[WIDTH-2:0], ~diff[WIDTH]};
    assign rn   = diff[WIDTH] ? sh[WIDTH-1:0] : diff[WIDTH-1:0];
`ifdef DIVIDER_SIGNED_EN
    logic neg_q, neg_d, rneg_q, rneg_d, sa, sb;
    always_comb begin
        sa     = bus.signed_op && bus.dividend[WIDTH-1];
        sb     = bus.signed_op && bus.divisor[WIDTH-1];
        a_mag  = sa ? -bus.dividend : bus.dividend;
        b_mag  = sb ? -bus.divisor : bus.divisor;
        ovf    = bus.signed_op && bus.dividend == {1'b1, {(WIDTH-1){1'b0}}} && &bus.divisor;
        neg_d  = acc ? sa ^ sb : neg_q;
        rneg_d = acc ? sa : rneg_q;
        q_res  = neg_q ? -qn : qn;
        r_res  = rneg_q ? -rn : rn;
    end
    always_ff @(posedge clock or negedge reset)
        if (!reset) {neg_q, rneg_q} <= '0;
        else {neg_q, rneg_q} <= {neg_d, rneg_d};
`else
    always_comb begin
        a_mag = bus.dividend;
        b_mag = bus.divisor;
        ovf   = 1'b0;
        q_res = qn;
        r_res = rn;
    end
`endif
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        dvs_d       = dvs_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        done_d      = done_q;
        busy_d      = busy_q;
        dbz_d       = dbz_q;
        dz_d        = dz_q;
        short_d     = short_q;
        if (acc) begin
            // zero divisor and signed overflow bypass iteration; their results wait in quo/rem
            state_d = BUSY;
            busy_d  = 1'b1;
            done_d  = 1'b0;
            dz_d    = bus.divisor == '0;
            short_d = dz_d || ovf;
            cnt_d   = short_d ? '0 : CW'(WIDTH - 1);
            quo_d   = dz_d ? '1 : ovf ? bus.dividend : a_mag;
            rem_d   = dz_d ? bus.dividend : '0;
            dvs_d   = b_mag;
            dbz_d   = dz_d && dbz_q;
        end else if (state_q == BUSY) begin
            quo_d = qn;
            rem_d = rn;
            cnt_d = cnt_q - 1'b1;
            if (short_q || cnt_q == '0) begin
                state_d     = DONE;
                busy_d      = 1'b0;
                done_d      = 1'b1;
                dbz_d       = dz_q;
                cnt_d       = '0;
                quotient_d  = short_q ? quo_q : q_res;
                remainder_d = short_q ? rem_q : r_res;
            end
        end
    end
    always_ff @(posedge clock or negedge reset)
        if (!reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            dvs_q       <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
            dbz_q       <= 1'b0;
            dz_q        <= 1'b0;
            short_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            dvs_q       <= dvs_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
            dbz_q       <= dbz_d;
            dz_q        <= dz_d;
            short_q     <= short_d;
        end
    assign bus.quotient    = quotient_q;
    assign bus.remainder   = remainder_q;
    assign bus.done        = done_q;
    assign bus.busy        = busy_q;
    assign bus.div_by_zero = dbz_q;
endmodule

// File: tb/tb_divider.sv
// tb_divider: self-checking bench for divider (directed table, reset and back-to-back cases, random vs model).
module tb_divider;
    logic clock = 1'b0, reset = 1'b0;
    int   tests = 0, fails = 0;
    logic [63:0] last_q = '0;
    divider_if #(.WIDTH(64)) bus();
    divider #(.WIDTH(64)) dut(.clock(clock), .reset(reset), .bus(bus));
    always #5 clock = ~clock;

    typedef struct {
        logic [63:0] a, b;
        logic        s;
        logic [63:0] q, r;
        logic        dz;
        int          lat;
    } vec_t;
    vec_t vt[$];

    task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endtask

    function automatic void model(input logic [63:0] a, input logic [63:0] b, input logic s,
                                  output logic [63:0] q, output logic [63:0] r,
                                  output logic dz, output int lat);
        dz  = b == 0;
        lat = 64;
        if (b == 0) begin
            q = '1; r = a; lat = 1;
        end
`ifdef DIVIDER_SIGNED_EN
        else if (s && a == 64'h8000_0000_0000_0000 && b == '1) begin
            q = a; r = 0; lat = 1;
        end else if (s) begin
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
        end
`endif
        else begin
            q = a / b; r = a % b;
        end
    endfunction

    task automatic do_div(input vec_t v, input string n);
        int lat = 0;
        @(negedge clock);
        bus.start = 1'b1; bus.dividend = v.a; bus.divisor = v.b; bus.signed_op = v.s;
        @(posedge clock); #1;
        bus.start = 1'b0;
        chk({n, "_done_at_accept"}, {63'd0, bus.done}, 64'd0);
        chk({n, "_busy_at_accept"}, {63'd0, bus.busy}, 64'd1);
        chk({n, "_q_held_busy"}, bus.quotient, last_q);
        bus.dividend = {$urandom, $urandom};
        bus.divisor = {$urandom, $urandom};
        bus.signed_op = ~v.s;
        while (!bus.done && lat < 200) begin
            @(posedge clock); #1;
            lat++;
        end
        chk({n, "_latency"}, 64'(lat), 64'(v.lat));
        chk({n, "_quotient"}, bus.quotient, v.q);
        chk({n, "_remainder"}, bus.remainder, v.r);
        chk({n, "_dbz"}, {63'd0, bus.div_by_zero}, {63'd0, v.dz});
        chk({n, "_busy_end"}, {63'd0, bus.busy}, 64'd0);
        last_q = v.q;
    endtask

    initial begin
        vec_t v;
        bus.start = 1'b0; bus.signed_op = 1'b0; bus.dividend = '0; bus.divisor = '0;
        vt.push_back('{64'd5, 64'd0, 1'b0, '1, 64'd5, 1'b1, 1});
        vt.push_back('{64'd100, 64'd7, 1'b0, 64'd14, 64'd2, 1'b0, 64});
        vt.push_back('{64'd0, 64'd0, 1'b0, '1, 64'd0, 1'b1, 1});
        vt.push_back('{64'd1000, 64'd10, 1'b0, 64'd100, 64'd0, 1'b0, 64});
        vt.push_back('{64'd7, 64'd8, 1'b0, 64'd0, 64'd7, 1'b0, 64});
        vt.push_back('{'1, 64'd1, 1'b0, '1, 64'd0, 1'b0, 64});
        vt.push_back('{64'd1, '1, 1'b0, 64'd0, 64'd1, 1'b0, 64});
        vt.push_back('{'1, '1, 1'b0, 64'd1, 64'd0, 1'b0, 64});
        vt.push_back('{64'd100, 64'd7, 1'b1, 64'd14, 64'd2, 1'b0, 64});
`ifdef DIVIDER_SIGNED_EN
        vt.push_back('{-64'sd20, 64'd5, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 64'd0, 1'b0, 64});
        vt.push_back('{-64'sd7, 64'd2, 1'b1, -64'sd3, -64'sd1, 1'b0, 64});
        vt.push_back('{64'h8000_0000_0000_0000, '1, 1'b1, 64'h8000_0000_0000_0000, 64'd0, 1'b0, 1});
        vt.push_back('{64'd7, -64'sd2, 1'b1, -64'sd3, 64'd1, 1'b0, 64});
        vt.push_back('{-64'sd5, 64'd0, 1'b1, '1, -64'sd5, 1'b1, 1});
`endif
        #1;
        chk("reset_done", {63'd0, bus.done}, 64'd0);
        chk("reset_busy", {63'd0, bus.busy}, 64'd0);
        chk("reset_quotient", bus.quotient, 64'd0);
        chk("reset_remainder", bus.remainder, 64'd0);
        chk("reset_dbz", {63'd0, bus.div_by_zero}, 64'd0);
        @(posedge clock); #2;
        reset = 1'b1;
        foreach (vt[i]) do_div(vt[i], $sformatf("vec%0d", i));

        // reset in the middle of a division, then an immediate new request
        @(negedge clock);
        bus.start = 1'b1; bus.dividend = 64'd100; bus.divisor = 64'd7; bus.signed_op = 1'b0;
        @(negedge clock);
        bus.start = 1'b0;
        repeat (30) @(negedge clock);
        reset = 1'b0;
        #1;
        chk("midrst_done", {63'd0, bus.done}, 64'd0);
        chk("midrst_busy", {63'd0, bus.busy}, 64'd0);
        chk("midrst_quotient", bus.quotient, 64'd0);
        chk("midrst_remainder", bus.remainder, 64'd0);
        chk("midrst_dbz", {63'd0, bus.div_by_zero}, 64'd0);
        last_q = '0;
        @(posedge clock); #2;
        reset = 1'b1;
        do_div('{64'd9, 64'd3, 1'b0, 64'd3, 64'd0, 1'b0, 64}, "after_rst");
        do_div('{64'd1000, 64'd10, 1'b0, 64'd100, 64'd0, 1'b0, 64}, "b2b");

        for (int k = 0; k < 20; k++) begin
            v.a = {$urandom, $urandom};
            v.b = $urandom_range(0, 2) == 0 ? {32'd0, $urandom} : {$urandom, $urandom};
            if ($urandom_range(0, 9) == 0) v.b = '0;
            v.s = 1'($urandom_range(0, 1));
            model(v.a, v.b, v.s, v.q, v.r, v.dz, v.lat);
            do_div(v, $sformatf("rnd%0d", k));
`ifdef DIVIDER_SIGNED_EN
            if (!v.s && v.b != 0) begin
`else
            if (v.b != 0) begin
`endif
                chk($sformatf("rnd%0d_identity", k), bus.quotient * v.b + bus.remainder, v.a);
                chk($sformatf("rnd%0d_rem_lt", k), {63'd0, bus.remainder < v.b}, 64'd1);
            end
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/divider.md
DIVIDER -- requirements
Module: divider

Interface
REQ-001 SHALL have parameter WIDTH, default 64: operand and result width in bits.
REQ-002 SHALL have port clock  input  1  rising-edge clock for all state.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port start  input  1  request new division; sampled at rising clock edges.
REQ-005 SHALL have port signed_op  input  1  treat operands as two's complement when high.
REQ-006 SHALL have port dividend  input  WIDTH  numerator.
REQ-007 SHALL have port divisor  input  WIDTH  denominator.
REQ-008 SHALL have port quotient  output  WIDTH  registered quotient.
REQ-009 SHALL have port remainder  output  WIDTH  registered remainder.
REQ-010 SHALL have port done  output  1  results valid; registered.
REQ-011 SHALL have port busy  output  1  iteration in progress; registered.
REQ-012 SHALL have port div_by_zero  output  1  last result had divisor==0; registered.

Function
REQ-013 SHALL implement FSM states IDLE, BUSY, DONE.
REQ-014 SHALL accept start=1 in IDLE or DONE: latch dividend, divisor and signed_op; clear done; enter BUSY; set busy=1.
REQ-015 SHALL ignore start and all operand inputs while in BUSY.
REQ-016 SHALL use radix-2 restoring division: one quotient bit per clock, MSB first, iteration counter loaded with WIDTH-1.
REQ-017 SHALL, when start is accepted at edge N with divisor!=0, assert done and update quotient/remainder at edge N+WIDTH, then enter DONE with busy=0.
REQ-018 SHALL, when start is accepted with divisor==0, complete at edge N+1 with quotient=all ones, remainder=dividend, div_by_zero=1.
REQ-019 SHALL clear div_by_zero on every accepted start with divisor!=0.
REQ-020 SHALL hold done=1 and quotient/remainder stable in DONE until the next accepted start.
REQ-021 SHALL allow start in the same cycle done is high (DONE state); done falls at the accepting edge.
REQ-022 SHALL, in unsigned mode, satisfy dividend == quotient*divisor + remainder with remainder < divisor (mod 2^WIDTH).
REQ-023 SHALL keep quotient/remainder unchanged during BUSY; partial results stay internal.

Reset
REQ-024 SHALL, on reset low, immediately force state IDLE, done=0, busy=0, div_by_zero=0, quotient=0, remainder=0, counter=0, regardless of state.
REQ-025 SHALL abandon any in-flight division on reset and produce no done pulse for it.
REQ-026 SHALL accept start at the first rising edge after reset returns high.

Configuration
REQ-027 SHALL recognise the macro DIVIDER_SIGNED_EN.
REQ-028 SHALL, with DIVIDER_SIGNED_EN defined and signed_op=1, divide operand magnitudes: quotient negated when operand signs differ; remainder takes the sign of dividend; latency unchanged.
REQ-029 SHALL, with DIVIDER_SIGNED_EN defined, return quotient=dividend, remainder=0 for the overflow case dividend=most-negative, divisor=-1, completing at edge N+1.
REQ-030 SHALL, with DIVIDER_SIGNED_EN defined, return quotient=all ones, remainder=dividend for signed divide-by-zero.
REQ-031 SHALL, without DIVIDER_SIGNED_EN, ignore signed_op, build no sign logic and perform only unsigned division.

Verification
REQ-032 SHALL cover unsigned 100/7, WIDTH=64 -> done exactly 64 edges after start, quotient=14, remainder=2, div_by_zero=0.
REQ-033 SHALL cover 5/0 -> done 1 edge after start, quotient=FFFF_FFFF_FFFF_FFFF, remainder=5, div_by_zero=1.
REQ-034 SHALL cover DIVIDER_SIGNED_EN, signed_op=1: -20/5 -> quotient=FFFF_FFFF_FFFF_FFFC, remainder=0; -7/2 -> quotient=-3, remainder=-1; 8000_0000_0000_0000/-1 -> quotient=8000_0000_0000_0000, remainder=0 after 1 edge.
REQ-035 SHALL cover reset driven low 30 cycles into a division -> done=0, busy=0, outputs 0 immediately; next start 9/3 -> quotient=3, remainder=0 after 64 edges.
REQ-036 SHALL cover start held high in DONE with new operands 1000/10 and operand changes during BUSY -> done drops at accept edge; result quotient=100, remainder=0 uses latched operands.
REQ-037 SHALL cover 10 us of random 64-bit operand pairs back-to-back -> every done shows quotient*divisor+remainder==dividend and remainder<divisor (unsigned).
